// File: rtl/player_bullet_controller.sv
// Player bullet pool: spawns at the muzzle on fire, climbs once per frame, retires off-screen or on hit.
// Define BULLET_AUTOFIRE_EN to re-arm the fire request every cycle while fire_btn is held.
module player_bullet_controller #(
  parameter int unsigned BULLET_COUNT    = 8,
  parameter int unsigned BULLET_SPEED    = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned SPAWN_X_OFFSET  = 14,
  parameter int unsigned SPAWN_Y_OFFSET  = 4
) (
  input  logic                         clk25,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         fire_btn,
  input  logic                         clear_all,
  input  logic [9:0]                   player_x,
  input  logic [9:0]                   player_y,
  input  logic [BULLET_COUNT-1:0]      bullet_hit,
  output logic [10*BULLET_COUNT-1:0]   bullet_x,
  output logic [10*BULLET_COUNT-1:0]   bullet_y,
  output logic [BULLET_COUNT-1:0]      bullet_active,
  output logic [15:0]                  shots_fired,
  output logic                         pool_full
);

  localparam int unsigned CW   = 10;
  localparam int unsigned SW   = 16;
  localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 2);

  localparam logic [CW-1:0]   SPEED     = CW'(BULLET_SPEED);
  localparam logic [CW-1:0]   X_OFF     = CW'(SPAWN_X_OFFSET);
  localparam logic [CW-1:0]   Y_OFF     = CW'(SPAWN_Y_OFFSET);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_FRAMES);
  localparam logic [SW-1:0]   SHOTS_MAX = {SW{1'b1}};

  logic [CW-1:0]           x_q [BULLET_COUNT];
  logic [CW-1:0]           x_d [BULLET_COUNT];
  logic [CW-1:0]           y_q [BULLET_COUNT];
  logic [CW-1:0]           y_d [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] act_q, act_d;
  logic [SW-1:0]           shots_q, shots_d;
  logic                    full_q, full_d;
  logic                    pend_q, pend_d;
  logic [CD_W-1:0]         cool_q, cool_d;

  logic                    pend_set_c;
  logic                    spawn_c;
  logic                    found_c;
  logic [BULLET_COUNT-1:0] spawn_sel_c;
  logic [CW-1:0]           spawn_x_c;
  logic [CW-1:0]           spawn_y_c;

`ifdef BULLET_AUTOFIRE_EN
  assign pend_set_c = fire_btn;
`else
  logic btn_q;

  // Edge detector resets low so a button held through reset fires once on release.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= fire_btn;
  end

  assign pend_set_c = fire_btn & ~btn_q;
`endif

  // Lowest-index slot free at the start of the cycle; slots freed this cycle are not eligible.
  always_comb begin
    spawn_sel_c = '0;
    found_c     = 1'b0;
    for (int j = 0; j < BULLET_COUNT; j++) begin
      if (!act_q[j] && !found_c) begin
        spawn_sel_c[j] = 1'b1;
        found_c        = 1'b1;
      end
    end
  end

  assign spawn_x_c = player_x + X_OFF;
  assign spawn_y_c = (player_y < Y_OFF) ? '0 : (player_y - Y_OFF);
  assign spawn_c   = frame_tick & pend_q & (cool_q == '0) & found_c & ~clear_all;

  always_comb begin
    act_d   = act_q;
    x_d     = x_q;
    y_d     = y_q;
    pend_d  = pend_q;
    cool_d  = cool_q;
    shots_d = shots_q;
    if (clear_all) begin
      act_d  = '0;
      pend_d = 1'b0;
      cool_d = '0;
    end else begin
      // Hit beats motion; a bullet hit on a frame tick retires in place.
      for (int j = 0; j < BULLET_COUNT; j++) begin
        if (act_q[j]) begin
          if (bullet_hit[j]) begin
            act_d[j] = 1'b0;
          end else if (frame_tick) begin
            if (y_q[j] >= SPEED) y_d[j] = y_q[j] - SPEED;
            else                 act_d[j] = 1'b0;
          end
        end else if (spawn_c && spawn_sel_c[j]) begin
          x_d[j]   = spawn_x_c;
          y_d[j]   = spawn_y_c;
          act_d[j] = 1'b1;
        end
      end
      if (pend_set_c)   pend_d = 1'b1;
      else if (spawn_c) pend_d = 1'b0;
      if (spawn_c) begin
        cool_d = CD_LOAD;
        if (shots_q != SHOTS_MAX) shots_d = shots_q + SW'(1);
      end else if (frame_tick && (cool_q != '0)) begin
        cool_d = cool_q - CD_W'(1);
      end
    end
    full_d = &act_d;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
        x_q[j] <= '0;
        y_q[j] <= '0;
      end
      act_q   <= '0;
      shots_q <= '0;
      full_q  <= 1'b0;
      pend_q  <= 1'b0;
      cool_q  <= '0;
    end else begin
      for (int j = 0; j < BULLET_COUNT; j++) begin
        x_q[j] <= x_d[j];
        y_q[j] <= y_d[j];
      end
      act_q   <= act_d;
      shots_q <= shots_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      cool_q  <= cool_d;
    end
  end

  for (genvar j = 0; j < BULLET_COUNT; j++) begin : g_pack
    assign bullet_x[CW*j +: CW] = x_q[j];
    assign bullet_y[CW*j +: CW] = y_q[j];
  end

  assign bullet_active = act_q;
  assign shots_fired   = shots_q;
  assign pool_full     = full_q;

endmodule

// File: tb/tb_player_bullet_controller.sv
// Directed bench for player_bullet_controller with a cycle-level behavioural model of the bullet pool.
module tb_player_bullet_controller;

  localparam int N   = 8;
  localparam int SPD = 4;
  localparam int CD  = 8;
  localparam int XO  = 14;
  localparam int YO  = 4;

  logic            clk25 = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_tick = 1'b0;
  logic            fire_btn = 1'b0;
  logic            clear_all = 1'b0;
  logic [9:0]      player_x = 10'd0;
  logic [9:0]      player_y = 10'd0;
  logic [N-1:0]    bullet_hit = '0;
  logic [10*N-1:0] bullet_x;
  logic [10*N-1:0] bullet_y;
  logic [N-1:0]    bullet_active;
  logic [15:0]     shots_fired;
  logic            pool_full;

  int vectors = 0;
  int miscompares = 0;

  player_bullet_controller #(
    .BULLET_COUNT(N), .BULLET_SPEED(SPD), .COOLDOWN_FRAMES(CD),
    .SPAWN_X_OFFSET(XO), .SPAWN_Y_OFFSET(YO)
  ) dut (
    .clk25(clk25), .rst_n(rst_n), .frame_tick(frame_tick), .fire_btn(fire_btn),
    .clear_all(clear_all), .player_x(player_x), .player_y(player_y),
    .bullet_hit(bullet_hit), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .shots_fired(shots_fired), .pool_full(pool_full)
  );

  always #20 clk25 = ~clk25;

  // Behavioural model: plain integers, rules applied in priority order each cycle.
  int mx [N];
  int my [N];
  bit mact [N];
  int mshots = 0;
  bit mpend = 0;
  int mcool = 0;
  bit mprev = 0;
  bit mfull = 0;
  int m_slot;
  bit m_req;
  bit m_spawn;

  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        mx[j] = 0; my[j] = 0; mact[j] = 0;
      end
      mshots = 0; mpend = 0; mcool = 0; mprev = 0; mfull = 0;
    end else begin
      m_slot = -1;
      for (int j = 0; j < N; j++) if (!mact[j] && m_slot < 0) m_slot = j;
`ifdef BULLET_AUTOFIRE_EN
      m_req = fire_btn;
`else
      m_req = fire_btn && !mprev;
`endif
      mprev = fire_btn;
      if (clear_all) begin
        for (int j = 0; j < N; j++) mact[j] = 0;
        mpend = 0;
        mcool = 0;
      end else begin
        m_spawn = frame_tick && mpend && (mcool == 0) && (m_slot >= 0);
        for (int j = 0; j < N; j++) begin
          if (mact[j]) begin
            if (bullet_hit[j]) mact[j] = 0;
            else if (frame_tick) begin
              if (my[j] >= SPD) my[j] = my[j] - SPD;
              else mact[j] = 0;
            end
          end
        end
        if (m_spawn) begin
          mx[m_slot] = (int'(player_x) + XO) % 1024;
          my[m_slot] = (int'(player_y) >= YO) ? int'(player_y) - YO : 0;
          mact[m_slot] = 1;
          mpend = 0;
          mcool = CD;
          if (mshots < 65535) mshots = mshots + 1;
        end else if (frame_tick && mcool > 0) begin
          mcool = mcool - 1;
        end
        if (m_req) mpend = 1;
      end
      mfull = 1;
      for (int j = 0; j < N; j++) if (!mact[j]) mfull = 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [10*N-1:0] ex, ey;
    logic [N-1:0] ea;
    for (int j = 0; j < N; j++) begin
      ex[10*j +: 10] = 10'(mx[j]);
      ey[10*j +: 10] = 10'(my[j]);
      ea[j] = mact[j];
    end
    chk("active", 128'(bullet_active), 128'(ea));
    chk("pos_x", 128'(bullet_x), 128'(ex));
    chk("pos_y", 128'(bullet_y), 128'(ey));
    chk("shots", 128'(shots_fired), 128'(16'(mshots)));
    chk("pool_full", 128'(pool_full), 128'(mfull));
  endtask

  task automatic cycle();
    @(posedge clk25);
    #1;
    compare_all();
  endtask

  task automatic tick();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0; cycle();
  endtask

  task automatic pulse();
    fire_btn = 1'b1; cycle();
    fire_btn = 1'b0; cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cycle(); cycle();
    rst_n = 1'b1; cycle();
  endtask

  task automatic do_clear();
    clear_all = 1'b1; cycle();
    clear_all = 1'b0; cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    player_x = 10'd100;
    player_y = 10'd400;
    do_reset();
    chk("reset_active", 128'(bullet_active), 128'(0));
    chk("reset_shots", 128'(shots_fired), 128'(0));

    // First shot and first move
    pulse();
    tick();
    chk("A_act0", 128'(bullet_active[0]), 128'(1));
    chk("A_x0", 128'(bullet_x[9:0]), 128'(114));
    chk("A_y0", 128'(bullet_y[9:0]), 128'(396));
    chk("A_shots", 128'(shots_fired), 128'(1));
    tick();
    chk("A_y0_move", 128'(bullet_y[9:0]), 128'(392));

    // Off-screen retire at y=3
    do_clear();
    player_y = 10'd7;
    pulse();
    tick();
    chk("B_y0", 128'(bullet_y[9:0]), 128'(3));
    tick();
    chk("B_act0", 128'(bullet_active[0]), 128'(0));
    chk("B_y0_hold", 128'(bullet_y[9:0]), 128'(3));

    // Fill the pool, ninth request waits for a hit-freed slot
    player_y = 10'd400;
    do_reset();
    for (int k = 0; k < N; k++) begin
      pulse();
      tick();
      for (int t = 0; t < CD; t++) tick();
    end
    chk("C_all_active", 128'(bullet_active), 128'(8'hFF));
    chk("C_full", 128'(pool_full), 128'(1));
    chk("C_shots8", 128'(shots_fired), 128'(8));
    pulse();
    tick();
    tick();
    chk("C_pending_shots", 128'(shots_fired), 128'(8));
    bullet_hit = 8'h01; cycle();
    bullet_hit = 8'h00; cycle();
    chk("C_hit_act0", 128'(bullet_active[0]), 128'(0));
    chk("C_hit_full", 128'(pool_full), 128'(0));
    tick();
    chk("C_respawn_act0", 128'(bullet_active[0]), 128'(1));
    chk("C_respawn_y0", 128'(bullet_y[9:0]), 128'(396));
    chk("C_shots9", 128'(shots_fired), 128'(9));
    chk("C_full_again", 128'(pool_full), 128'(1));

    // Cooldown spacing: second edge 3 ticks after first spawn
    do_reset();
    pulse();
    tick();
    got = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 3) pulse();
      tick();
      if (shots_fired == 16'd2 && got == 0) got = t;
    end
    chk("D_spacing", 128'(got), 128'(9));

    // Hit coincident with frame tick, and hit on an idle slot
    pulse();
    tick();
    chk("E_act2", 128'(bullet_active[2]), 128'(1));
    bullet_hit = 8'h04; frame_tick = 1'b1; cycle();
    bullet_hit = 8'h00; frame_tick = 1'b0; cycle();
    chk("E_act2_hit", 128'(bullet_active[2]), 128'(0));
    chk("E_y2_hold", 128'(bullet_y[29:20]), 128'(396));
    bullet_hit = 8'h10; cycle();
    bullet_hit = 8'h00; cycle();
    chk("E_idle_hit", 128'(bullet_active), 128'(8'h03));

    // Spawn x wraps, spawn y saturates at 0 then retires
    do_clear();
    player_x = 10'd1020;
    player_y = 10'd2;
    pulse();
    tick();
    chk("F_x0_wrap", 128'(bullet_x[9:0]), 128'(10));
    chk("F_y0_sat", 128'(bullet_y[9:0]), 128'(0));
    chk("F_act0", 128'(bullet_active[0]), 128'(1));
    tick();
    chk("F_act0_top", 128'(bullet_active[0]), 128'(0));

    // Asynchronous reset mid-flight with the button held through it
    player_x = 10'd100;
    player_y = 10'd400;
    pulse();
    for (int t = 0; t < CD; t++) tick();
    pulse();
    tick();
    @(posedge clk25);
    #3;
    fire_btn = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("G_async_active", 128'(bullet_active), 128'(0));
    chk("G_async_shots", 128'(shots_fired), 128'(0));
    chk("G_async_y", 128'(bullet_y), 128'(0));
    cycle(); cycle();
    rst_n = 1'b1;
    for (int t = 0; t < 40; t++) tick();
`ifdef BULLET_AUTOFIRE_EN
    chk("G_hold_shots", 128'(shots_fired), 128'(5));
`else
    chk("G_hold_shots", 128'(shots_fired), 128'(1));
`endif
    fire_btn = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/player_bullet_controller.md
# player_bullet_controller

Owns the player's bullet pool: spawns bullets at the player's muzzle on a fire request and moves them upward once per video frame. Retires bullets that leave the top of the screen or that the hit-detection stage reports as having struck an enemy. Sits upstream of the enemy hit-detection block. It drives that block's bullet position/active inputs and consumes its per-bullet `bullet_hit` vector, closing the fire → move → hit → retire loop.

## Interface
Parameters:
- `BULLET_COUNT`, 8, number of bullet slots (must match hit-detection block)
- `BULLET_SPEED`, 4, pixels moved up per frame tick
- `COOLDOWN_FRAMES`, 8, minimum frame ticks between two spawns
- `SPAWN_X_OFFSET`, 14, added to `player_x` for spawn x
- `SPAWN_Y_OFFSET`, 4, subtracted from `player_y` for spawn y

Ports:
- `clk25`  in  1  25 MHz pixel clock, sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per frame (start of vblank)
- `fire_btn`  in  1  fire button, already synchronised/debounced, level
- `clear_all`  in  1  synchronous: retire all bullets, clear pending fire and cooldown
- `player_x`, `player_y`  in  10 each  player sprite top-left
- `bullet_hit`  in  BULLET_COUNT  per-slot hit report from hit detection, bit j = slot j
- `bullet_x`  out  10*BULLET_COUNT  packed, slot j at [10j+9:10j]
- `bullet_y`  out  10*BULLET_COUNT  packed, same layout
- `bullet_active`  out  BULLET_COUNT  slot occupied
- `shots_fired`  out  16  saturating count of spawns
- `pool_full`  out  1  all slots active (registered)

## Operation
- Fire request: rising edge of `fire_btn` sets `fire_pending`. The flag stays set until serviced or cleared.
- On `frame_tick`, all in one cycle:
  - Move: every active slot with `y >= BULLET_SPEED` gets `y -= BULLET_SPEED`. An active slot with `y < BULLET_SPEED` is retired (active←0). No wrap-around.
  - Spawn: if `fire_pending` and cooldown == 0 and a free slot exists, take the lowest-index slot free at the start of the cycle. Set x = player_x + SPAWN_X_OFFSET and y = player_y − SPAWN_Y_OFFSET. Both are 10-bit, truncating; y saturates at 0 if player_y < offset. Set active←1, clear `fire_pending`, load cooldown ← COOLDOWN_FRAMES, increment `shots_fired` (holds at 0xFFFF). A newly spawned bullet does not move that tick.
  - If the pool is full, `fire_pending` stays set and spawn retries on later ticks.
  - Otherwise, a nonzero cooldown decrements by 1.
- Hit retire: any cycle with `bullet_hit[j]`=1 and slot j active sets active←0. Hits on inactive slots are ignored. x/y keep their last values when inactive.
- Priority in one cycle: `clear_all` > hit retire > move/off-screen retire > spawn. A slot freed this cycle is not reusable for a spawn in the same cycle.

## Timing
- Reset values: all `bullet_active`=0; all x/y=0; `shots_fired`=0; `pool_full`=0; `fire_pending`=0; cooldown=0; fire edge detector register=0 (a button held through reset fires once on release of reset).
- All outputs are registered. Position and active updates are visible the cycle after `frame_tick`.
- Hit-detection is registered, so hits arrive one cycle after the positions they refer to. Retire occurs on the cycle after `bullet_hit` is seen, so a slot is inactive 2 cycles after the overlapping position appears.
- A `bullet_hit` coincident with `frame_tick` for the same slot retires it, and the slot does not move.
- Reset mid-flight: asynchronous clear of all state, effective immediately.

## Configuration
- `BULLET_AUTOFIRE_EN` defined: while `fire_btn` is held high, `fire_pending` is re-asserted every cycle. The result is one spawn every COOLDOWN_FRAMES+1 frame ticks, as slots allow.
- Not defined: only a rising edge of `fire_btn` sets `fire_pending`. Holding the button yields exactly one bullet.

## Test plan
- Reset, player at (100,400), pulse `fire_btn`, one `frame_tick` → slot0 active, x=114, y=396, `shots_fired`=1; next tick y=392.
- Bullet at y=3 (speed 4), `frame_tick` → slot retired, y stays 3, `bullet_active`[0]=0.
- Fire on 9 successive post-cooldown ticks with no hits and bullets far from top → slots 0–7 fill, `pool_full`=1, 9th request stays pending and spawns into slot 0 the tick after slot 0 is retired by `bullet_hit`=8'h01.
- Two fire edges 3 ticks apart with COOLDOWN_FRAMES=8 → second spawn occurs exactly 9 ticks after the first.
- `bullet_hit`=8'h04 with slot 2 active, coincident with `frame_tick` → slot 2 inactive, y unchanged. `bullet_hit`=8'h10 with slot 4 inactive → no change.
- Hold `fire_btn` 40 ticks → 1 bullet without `BULLET_AUTOFIRE_EN`; 5 bullets with it (ticks 1,10,19,28,37).
